// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the program counter, arbitrates branch/jump
// redirects against halt and load-use stalls, and drives IF/ID control.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 BranchTaken,
  input  logic [31:0]          BranchTarget,
  input  logic                 Jump,
  input  logic [31:0]          JumpTarget,
  input  logic                 Halt,
  output logic [31:0]          PCResult,
  output logic [31:0]          PCAddResult,
  output logic                 IFIDWrite,
  output logic                 IFIDFlush,
  output logic                 IDEXFlush,
  output logic                 Halted,
  output logic                 AlignErr,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] RedirectCount
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // One winner per cycle, listed in priority order.
  typedef enum logic [2:0] {
    SEL_RESET  = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_HALT   = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_STALL  = 3'd4,
    SEL_SEQ    = 3'd5
  } sel_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t      state, state_next;
  sel_t        sel;
  logic [31:0] pc_next;
  logic [31:0] target_raw;
  logic        redirect;

  assign PCAddResult = PCResult + 32'd4;
  assign Halted      = (state == ST_HALT);
  assign redirect    = (sel == SEL_BRANCH) || (sel == SEL_JUMP);
  assign target_raw  = (sel == SEL_BRANCH) ? BranchTarget : JumpTarget;

  // Priority arbitration. While halted, Jump/Stall/Halt are ignored, so the
  // halt state folds into the Halt request below the branch.
  always_comb begin : arbitrate
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sel = SEL_SEQ;
    if (Reset)                             sel = SEL_RESET;
    else if (BranchTaken)                  sel = SEL_BRANCH;
    else if (Halt || (state == ST_HALT))   sel = SEL_HALT;
    else if (Jump)                         sel = SEL_JUMP;
    else if (Stall)                        sel = SEL_STALL;
  end

  // State register.
  always_ff @(posedge Clk) begin : state_reg
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin : next_state
    state_next = ST_RUN;
    case (sel)
      SEL_HALT:  state_next = ST_HALT;
      SEL_STALL: state_next = ST_STALL;
      default:   state_next = ST_RUN;
    endcase
  end

  // Output and PC-select logic.
  always_comb begin : outputs
    IFIDWrite = ~(Stall | Halted | Halt);
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    AlignErr  = 1'b0;
    pc_next   = PCResult;
    case (sel)
      SEL_RESET: begin
        IFIDWrite = 1'b0;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        pc_next   = RESET_PC;
      end
      SEL_BRANCH: begin
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
        AlignErr  = |target_raw[1:0];
        pc_next   = {target_raw[31:2], 2'b00};
      end
      SEL_JUMP: begin
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b1;
        AlignErr  = |target_raw[1:0];
        pc_next   = {target_raw[31:2], 2'b00};
      end
      SEL_HALT: begin
        IFIDWrite = 1'b0;
        pc_next   = PCResult;
      end
      SEL_STALL: begin
        IFIDWrite = 1'b0;
        pc_next   = PCResult;
      end
      default: begin
        IFIDWrite = 1'b1;
        pc_next   = PCAddResult;
      end
    endcase
  end

  // PC register; wraps modulo 2^32 with no flag.
  always_ff @(posedge Clk) begin : pc_reg
    if (Reset) PCResult <= RESET_PC;
    else       PCResult <= pc_next;
  end

  // Saturating debug counters; halt cycles are not counted as stalls.
  always_ff @(posedge Clk) begin : counters
    if (Reset) begin
      StallCount    <= '0;
      RedirectCount <= '0;
    end else begin
      if ((sel == SEL_STALL) && (StallCount != CNT_MAX))
        StallCount <= StallCount + CNT_ONE;
      if (redirect && (RedirectCount != CNT_MAX))
        RedirectCount <= RedirectCount + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a per-cycle vector table followed by
// hand-written sequences for counter saturation, a long halt and reset mid-stall.
module tb_pc_sequencer;

  localparam logic [31:0] RP = 32'h0040_0000;
  localparam int          CW = 4;

  logic          clk;
  logic          rst, stall, br, jmp, halt;
  logic [31:0]   bt, jt;
  logic [31:0]   pc, pc_add;
  logic          wr, ff, xf, hlt, ae;
  logic [CW-1:0] sc, rc;

  pc_sequencer #(.RESET_PC(RP), .CNT_WIDTH(CW)) dut (
    .Clk(clk), .Reset(rst), .Stall(stall),
    .BranchTaken(br), .BranchTarget(bt),
    .Jump(jmp), .JumpTarget(jt), .Halt(halt),
    .PCResult(pc), .PCAddResult(pc_add),
    .IFIDWrite(wr), .IFIDFlush(ff), .IDEXFlush(xf),
    .Halted(hlt), .AlignErr(ae),
    .StallCount(sc), .RedirectCount(rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          rst, stall, br;
    logic [31:0]   bt;
    logic          jmp;
    logic [31:0]   jt;
    logic          halt;
    logic [31:0]   pc;
    logic          wr, ff, xf, hlt, ae;
    logic [CW-1:0] sc, rc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic r, input logic s, input logic b,
                     input logic [31:0] btv, input logic j, input logic [31:0] jtv,
                     input logic h, input logic [31:0] epc, input logic ewr,
                     input logic eff, input logic exf, input logic ehl, input logic eae,
                     input logic [CW-1:0] esc, input logic [CW-1:0] erc);
    vec_t v;
    v.name = name; v.rst = r; v.stall = s; v.br = b; v.bt = btv; v.jmp = j; v.jt = jtv;
    v.halt = h; v.pc = epc; v.wr = ewr; v.ff = eff; v.xf = exf; v.hlt = ehl; v.ae = eae;
    v.sc = esc; v.rc = erc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] btv,
                       input logic j, input logic [31:0] jtv, input logic h);
    rst = r; stall = s; br = b; bt = btv; jmp = j; jt = jtv; halt = h;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();

    //  name            rst stl br  bt            jmp jt            hlt  pc            wr ff xf hl ae sc rc
    add("reset",        1,  0,  0,  32'h0,        0,  32'h0,        0,   RP,           0, 1, 1, 0, 0, 0, 0);
    add("idle0",        0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h00400000, 1, 0, 0, 0, 0, 0, 0);
    add("idle1",        0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h00400004, 1, 0, 0, 0, 0, 0, 0);
    add("idle2",        0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h00400008, 1, 0, 0, 0, 0, 0, 0);
    add("idle3",        0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h0040000C, 1, 0, 0, 0, 0, 0, 0);
    add("stall0",       0,  1,  0,  32'h0,        0,  32'h0,        0,   32'h00400010, 0, 0, 0, 0, 0, 0, 0);
    add("stall1",       0,  1,  0,  32'h0,        0,  32'h0,        0,   32'h00400010, 0, 0, 0, 0, 0, 1, 0);
    add("stall2",       0,  1,  0,  32'h0,        0,  32'h0,        0,   32'h00400010, 0, 0, 0, 0, 0, 2, 0);
    add("release",      0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h00400010, 1, 0, 0, 0, 0, 3, 0);
    add("advance",      0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h00400014, 1, 0, 0, 0, 0, 3, 0);
    add("br_over_all",  0,  1,  1,  32'h00400100, 1,  32'h00400200, 0,   32'h00400018, 1, 1, 1, 0, 0, 3, 0);
    add("br_landed",    0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h00400100, 1, 0, 0, 0, 0, 3, 1);
    add("jmp_misalign", 0,  0,  0,  32'h0,        1,  32'h00000103, 0,   32'h00400104, 1, 1, 0, 0, 1, 3, 1);
    add("jmp_landed",   0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h00000100, 1, 0, 0, 0, 0, 3, 2);
    add("br_to_20",     0,  0,  1,  32'h00400020, 0,  32'h0,        0,   32'h00000104, 1, 1, 1, 0, 0, 3, 2);
    add("halt_req",     0,  0,  0,  32'h0,        0,  32'h0,        1,   32'h00400020, 0, 0, 0, 0, 0, 3, 3);
    add("halt_jmpstl",  0,  1,  0,  32'h0,        1,  32'h00001237, 0,   32'h00400020, 0, 0, 0, 1, 0, 3, 3);
    add("halt_stl",     0,  1,  0,  32'h0,        0,  32'h0,        0,   32'h00400020, 0, 0, 0, 1, 0, 3, 3);
    add("halt_hj",      0,  0,  0,  32'h0,        1,  32'h00000200, 1,   32'h00400020, 0, 0, 0, 1, 0, 3, 3);
    add("halt_idle",    0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h00400020, 0, 0, 0, 1, 0, 3, 3);
    add("halt_stl2",    0,  1,  0,  32'h0,        0,  32'h0,        0,   32'h00400020, 0, 0, 0, 1, 0, 3, 3);
    add("halt_br",      0,  0,  1,  32'h00400000, 0,  32'h0,        0,   32'h00400020, 1, 1, 1, 1, 0, 3, 3);
    add("unhalted",     0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h00400000, 1, 0, 0, 0, 0, 3, 4);
    add("br_top",       0,  0,  1,  32'hFFFFFFFC, 0,  32'h0,        0,   32'h00400004, 1, 1, 1, 0, 0, 3, 4);
    add("at_top",       0,  0,  0,  32'h0,        0,  32'h0,        0,   32'hFFFFFFFC, 1, 0, 0, 0, 0, 3, 5);
    add("wrapped",      0,  0,  0,  32'h0,        0,  32'h0,        0,   32'h00000000, 1, 0, 0, 0, 0, 3, 5);
    add("halt_over_j",  0,  0,  0,  32'h0,        1,  32'h00000301, 1,   32'h00000004, 0, 0, 0, 0, 0, 3, 5);
    add("rst_in_halt",  1,  0,  1,  32'h00000703, 0,  32'h0,        0,   32'h00000004, 0, 1, 1, 1, 0, 3, 5);
    add("post_reset",   0,  0,  0,  32'h0,        0,  32'h0,        0,   RP,           1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt, vecs[i].halt);
      #3;
      check({vecs[i].name, ".pc"},     pc,     vecs[i].pc);
      check({vecs[i].name, ".pcadd"},  pc_add, vecs[i].pc + 32'd4);
      check({vecs[i].name, ".wr"},     wr,     vecs[i].wr);
      check({vecs[i].name, ".ifidfl"}, ff,     vecs[i].ff);
      check({vecs[i].name, ".idexfl"}, xf,     vecs[i].xf);
      check({vecs[i].name, ".halted"}, hlt,    vecs[i].hlt);
      check({vecs[i].name, ".alnerr"}, ae,     vecs[i].ae);
      check({vecs[i].name, ".stlcnt"}, sc,     vecs[i].sc);
      check({vecs[i].name, ".redcnt"}, rc,     vecs[i].rc);
      tick();
    end

    // Stall counter saturation: 20 stalls on a 4-bit counter must stop at 15.
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      #3;
      check("sat_stall.pc", pc, RP + 32'd4);
      tick();
    end
    // Redirect counter saturation with back-to-back jumps.
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 1, 32'h0050_0000 + 32'(i * 8), 0);
      #3;
      if (i == 0) check("sat_stall.cnt", sc, 4'hF);
      check("sat_jmp.flush", ff, 1'b1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    #3;
    check("sat_jmp.cnt", rc, 4'hF);
    check("sat_jmp.pc", pc, 32'h0050_0098);
    tick();

    // Ten halted cycles with Jump and Stall toggling: PC must stay frozen.
    for (int i = 0; i < 10; i++) begin
      drive(0, (i % 2) == 0, 0, 0, (i % 2) == 1, 32'h0000_0040, 0);
      #3;
      check("halt10.pc", pc, 32'h0050_0098);
      check("halt10.halted", hlt, 1'b1);
      check("halt10.wr", wr, 1'b0);
      tick();
    end

    // Leave halt, stall, then reset in the middle of the stall.
    drive(0, 0, 1, RP, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    tick();
    #3;
    check("midstall.pc", pc, RP);
    drive(1, 1, 0, 0, 1, 32'h0000_0080, 0);
    #3;
    check("rst_stall.ifidfl", ff, 1'b1);
    check("rst_stall.idexfl", xf, 1'b1);
    check("rst_stall.wr", wr, 1'b0);
    check("rst_stall.alnerr", ae, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("after_rst.pc", pc, RP);
    check("after_rst.pcadd", pc_add, RP + 32'd4);
    check("after_rst.halted", hlt, 1'b0);
    check("after_rst.stlcnt", sc, 4'h0);
    check("after_rst.redcnt", rc, 4'h0);
    check("after_rst.wr", wr, 1'b1);
    check("after_rst.ifidfl", ff, 1'b0);
    check("after_rst.idexfl", xf, 1'b0);
    tick();
    #3;
    check("after_rst.advance", pc, RP + 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage sequencer that owns the program counter register and decides, every cycle, which address the PC loads next: PC+4, a taken-branch target from EX, a jump target from ID, or hold. It arbitrates these redirect sources against hazard stalls and a halt request, generates the pipeline flush and IF/ID write-enable controls, and keeps stall and redirect counters for debug. It sits between the hazard/branch logic and instruction memory, replacing the free-running PC register plus incrementor pair.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 0.
- CNT_WIDTH, 16: width of the saturating debug counters.

Ports:
- Clk  in  1  rising-edge clock; single clock domain.
- Reset  in  1  synchronous, active-high reset, sampled on the rising edge of Clk.
- Stall  in  1  load-use stall from hazard detection; freeze PC and IF/ID.
- BranchTaken  in  1  branch resolved taken in EX this cycle.
- BranchTarget  in  32  branch destination, valid with BranchTaken.
- Jump  in  1  J/JAL/JR decoded in ID this cycle.
- JumpTarget  in  32  jump destination, valid with Jump.
- Halt  in  1  halt decoded in ID; stop fetching.
- PCResult  out  32  current PC (registered) to instruction memory.
- PCAddResult  out  32  PCResult + 4 (combinational).
- IFIDWrite  out  1  IF/ID pipeline register write enable.
- IFIDFlush  out  1  squash IF/ID contents at the next edge.
- IDEXFlush  out  1  squash ID/EX contents at the next edge.
- Halted  out  1  high while in HALT state.
- AlignErr  out  1  one-cycle pulse: accepted target had nonzero bits [1:0].
- StallCount  out  CNT_WIDTH  cycles spent stalled, saturating.
- RedirectCount  out  CNT_WIDTH  redirects taken, saturating.

## Operation

- State machine with three states: RUN, STALL, HALT. STALL is entered on any cycle where Stall is high and no redirect wins; it is left the first cycle Stall is low.
- Per-cycle priority, highest first:
  1. Reset.
  2. BranchTaken: PC <= {BranchTarget[31:2],2'b00}; IFIDFlush=1, IDEXFlush=1; next state RUN.
  3. Halt: PC holds; IFIDWrite=0; next state HALT.
  4. Jump: PC <= {JumpTarget[31:2],2'b00}; IFIDFlush=1; next state RUN.
  5. Stall: PC holds; IFIDWrite=0; next state STALL.
  6. Otherwise: PC <= PC + 4; IFIDWrite=1.
- A branch overrides Stall, Halt and Jump in the same cycle, because those come from younger wrong-path instructions. Halt overrides Jump.
- HALT is absorbing. The PC holds, IFIDWrite=0, and the Jump, Stall and Halt inputs are ignored. Only Reset or BranchTaken leaves HALT. BranchTaken redirects and returns the block to RUN.
- In all non-redirect cycles IFIDWrite = ~(Stall | Halted | Halt). During a redirect cycle IFIDWrite=1 and IFIDFlush=1.
- AlignErr pulses for one cycle when the accepted redirect target has bits [1:0] != 0. The target is still loaded with those bits forced to 0.
- Arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- StallCount increments on every cycle where the PC holds due to Stall, not on HALT cycles. RedirectCount increments on every accepted branch or jump. Both counters saturate at all-ones and never wrap.

## Timing

- PCResult, state and counters are registered and update on the rising edge of Clk. PCAddResult and the flush, write and AlignErr outputs are combinational from the current state and inputs.
- Redirect latency: a target presented in cycle n appears on PCResult in cycle n+1. The instruction fetched in cycle n is squashed by IFIDFlush at the same edge.
- Stall release: the first cycle after Stall falls, PCResult still shows the held address. It advances at the following edge.
- Reset values: PCResult=RESET_PC, PCAddResult=RESET_PC+4, state RUN, Halted=0, StallCount=0, RedirectCount=0. While Reset is high, IFIDFlush=1, IDEXFlush=1, IFIDWrite=0 and AlignErr=0.
- Reset asserted mid-stall, mid-halt or in the same cycle as a redirect wins outright. No redirect or count is recorded.

## Test plan

- Reset with RESET_PC=0x0040_0000, then 4 idle cycles -> PCResult sequence 0x00400000, 04, 08, 0C, 10; IFIDWrite=1 and both flushes 0 after reset.
- Stall high for 3 cycles at PC=0x0040_0010 -> PCResult held 3 cycles, IFIDWrite=0, StallCount=3; then 0x0040_0014.
- BranchTaken=1 with target 0x0040_0100 in the same cycle as Stall=1 and Jump=1 (target 0x0040_0200) -> next PCResult=0x0040_0100, IFIDFlush=1, IDEXFlush=1, RedirectCount+1, StallCount unchanged.
- Jump to 0x0000_0103 -> PCResult=0x0000_0100, AlignErr pulses one cycle, IFIDFlush=1, IDEXFlush=0.
- Halt at PC=0x0040_0020 -> Halted=1, PC frozen for 10 cycles despite Jump and Stall toggling; a later BranchTaken to 0x0040_0000 -> PC=0x0040_0000, Halted=0.
- Force PC=0xFFFF_FFFC via branch, run 1 cycle -> PCResult=0x0000_0000. Preload the counters to all-ones via a long stall and redirects -> they stay at 0xFFFF. Reset mid-stall -> all outputs return to their reset values.
